// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: edge-detects request lines, masks with mie,
// arbitrates by fixed priority and sequences trap / service / return with the core.
module irq_controller #(
    parameter int unsigned IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               stall_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic               irq_ret_o,
    output logic [IRQ_NUM-1:0] irq_ack_o
);

    localparam int unsigned ID_W       = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
    localparam logic [31:0] CAUSE_BASE = 32'h8000_0010;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRAP    = 2'd1,
        S_SERVICE = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IRQ_NUM-1:0] req_q, req_d;
    logic [IRQ_NUM-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               rearm_q, rearm_d;
    logic               irq_q, irq_d;
    logic [31:0]        cause_q, cause_d;
    logic               ret_q, ret_d;
    logic [IRQ_NUM-1:0] ack_q, ack_d;

    logic [IRQ_NUM-1:0] rise;
    logic [IRQ_NUM-1:0] eligible;
    logic [IRQ_NUM-1:0] sel;
    logic [IRQ_NUM-1:0] clr;
    logic [ID_W-1:0]    win;
    logic               unused_mie;

    // Only the low IRQ_NUM enable bits matter; the rest are folded away.
    assign unused_mie = ^mie_i;

    function automatic logic [IRQ_NUM-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot = IRQ_NUM'(1) << idx;
    endfunction

    // Edge detection, masking and lowest-index-wins arbitration.
    always_comb begin
        req_d    = irq_req_i;
        rise     = irq_req_i & ~req_q;
        eligible = pending_q & mie_i[IRQ_NUM-1:0];
        win      = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win = ID_W'(i);
            end
        end
    end

    // A fresh edge on the in-service line after launch must survive the return clear.
    always_comb begin
        sel       = onehot(id_q);
        rearm_d   = ((state_q == S_TRAP) || (state_q == S_SERVICE)) && (rearm_q || (|(rise & sel)));
        clr       = ((state_q == S_RETURN) && !rearm_q) ? sel : '0;
        pending_d = (pending_q & ~clr) | rise;
    end

    // Next-state and registered Moore outputs.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if ((|eligible) && !stall_i) begin
                    state_d = S_TRAP;
                    id_d    = win;
                end
            end
            S_TRAP: begin
                if (!stall_i) begin
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (mret_i && !stall_i) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        irq_d   = (state_d == S_TRAP);
        ret_d   = (state_d == S_RETURN);
        ack_d   = ret_d ? onehot(id_d) : '0;
        cause_d = (state_d == S_IDLE) ? 32'h0 : (CAUSE_BASE | 32'(id_d));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            pending_q <= '0;
            id_q      <= '0;
            rearm_q   <= 1'b0;
            irq_q     <= 1'b0;
            cause_q   <= 32'h0;
            ret_q     <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            rearm_q   <= rearm_d;
            irq_q     <= irq_d;
            cause_q   <= cause_d;
            ret_q     <= ret_d;
            ack_q     <= ack_d;
        end
    end

    assign irq_o       = irq_q;
    assign irq_cause_o = cause_q;
    assign irq_ret_o   = ret_q;
    assign irq_ack_o   = ack_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_irq_controller;

    localparam int unsigned IRQ_NUM = 16;

    logic               clk;
    logic               rst;
    logic [IRQ_NUM-1:0] irq_req;
    logic [31:0]        mie;
    logic               stall;
    logic               mret;
    logic               irq;
    logic [31:0]        irq_cause;
    logic               irq_ret;
    logic [IRQ_NUM-1:0] irq_ack;

    int n_checks = 0;
    int n_fail   = 0;

    irq_controller #(.IRQ_NUM(IRQ_NUM)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_req_i   (irq_req),
        .mie_i       (mie),
        .stall_i     (stall),
        .mret_i      (mret),
        .irq_o       (irq),
        .irq_cause_o (irq_cause),
        .irq_ret_o   (irq_ret),
        .irq_ack_o   (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_req = '0; mie = 32'h0; stall = 1'b0; mret = 1'b0;
        cyc(); cyc();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_checks++; if (irq_cause !== 32'h0) begin n_fail++; $display("FAIL reset_cause: got %h want 0", irq_cause); end
        n_checks++; if (irq_ret !== 1'b0) begin n_fail++; $display("FAIL reset_ret: got %b want 0", irq_ret); end
        n_checks++; if (irq_ack !== 16'h0) begin n_fail++; $display("FAIL reset_ack: got %h want 0", irq_ack); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        mie = 32'h1;
        irq_req[0] = 1'b1;
        cyc();
        irq_req[0] = 1'b0;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_early: irq got %b want 0", irq); end
        cyc();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b want 1", irq); end
        n_checks++; if (irq_cause !== 32'h8000_0010) begin n_fail++; $display("FAIL single_cause: got %h want 80000010", irq_cause); end
        cyc();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: irq got %b want 0", irq); end
        n_checks++; if (irq_ret !== 1'b0) begin n_fail++; $display("FAIL single_no_ret: got %b want 0", irq_ret); end
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        n_checks++; if (irq_ret !== 1'b1) begin n_fail++; $display("FAIL single_ret: got %b want 1", irq_ret); end
        n_checks++; if (irq_ack !== 16'h0001) begin n_fail++; $display("FAIL single_ack: got %h want 0001", irq_ack); end
        cyc();
        n_checks++; if (irq_ret !== 1'b0 || irq_ack !== 16'h0) begin n_fail++; $display("FAIL single_ret_pulse: ret=%b ack=%h want 0/0000", irq_ret, irq_ack); end
        n_checks++; if (irq_cause !== 32'h0) begin n_fail++; $display("FAIL single_idle_cause: got %h want 0", irq_cause); end
        n_checks++; if (dut.pending_q !== 16'h0) begin n_fail++; $display("FAIL single_pending_clr: got %h want 0000", dut.pending_q); end
        cyc();
    endtask

    task automatic test_priority();
        mie = 32'hFFFF;
        irq_req = 16'h0028;
        cyc();
        irq_req = '0;
        cyc();
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0013) begin n_fail++; $display("FAIL prio_first: irq=%b cause=%h want 1/80000013", irq, irq_cause); end
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        n_checks++; if (irq_ack !== 16'h0008) begin n_fail++; $display("FAIL prio_ack3: got %h want 0008", irq_ack); end
        cyc();
        n_checks++; if (irq !== 1'b0 || irq_cause !== 32'h0) begin n_fail++; $display("FAIL prio_idle_gap: irq=%b cause=%h want 0/0", irq, irq_cause); end
        cyc();
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0015) begin n_fail++; $display("FAIL prio_second: irq=%b cause=%h want 1/80000015", irq, irq_cause); end
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        n_checks++; if (irq_ack !== 16'h0020) begin n_fail++; $display("FAIL prio_ack5: got %h want 0020", irq_ack); end
        cyc(); cyc();
    endtask

    task automatic test_mask();
        logic seen;
        mie = 32'h0;
        irq_req[2] = 1'b1;
        cyc();
        irq_req[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (irq !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_hold: irq seen=%b want 0", seen); end
        mie = 32'h4;
        cyc();
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0012) begin n_fail++; $display("FAIL mask_enable: irq=%b cause=%h want 1/80000012", irq, irq_cause); end
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        n_checks++; if (irq_ack !== 16'h0004) begin n_fail++; $display("FAIL mask_ack: got %h want 0004", irq_ack); end
        cyc(); cyc();
    endtask

    task automatic test_stall();
        mie = 32'hFFFF;
        irq_req[4] = 1'b1;
        cyc();
        irq_req[4] = 1'b0;
        cyc();
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0014) begin n_fail++; $display("FAIL stall_trap: irq=%b cause=%h want 1/80000014", irq, irq_cause); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0014) begin n_fail++; $display("FAIL stall_hold%0d: irq=%b cause=%h want 1/80000014", i, irq, irq_cause); end
        end
        stall = 1'b0;
        cyc();
        n_checks++; if (irq !== 1'b0 || irq_cause !== 32'h8000_0014) begin n_fail++; $display("FAIL stall_release: irq=%b cause=%h want 0/80000014", irq, irq_cause); end
        mret = 1'b1; stall = 1'b1;
        cyc();
        n_checks++; if (irq_ret !== 1'b0) begin n_fail++; $display("FAIL stall_mret0: ret got %b want 0", irq_ret); end
        cyc();
        n_checks++; if (irq_ret !== 1'b0) begin n_fail++; $display("FAIL stall_mret1: ret got %b want 0", irq_ret); end
        stall = 1'b0;
        cyc();
        mret = 1'b0;
        n_checks++; if (irq_ret !== 1'b1 || irq_ack !== 16'h0010) begin n_fail++; $display("FAIL stall_ret: ret=%b ack=%h want 1/0010", irq_ret, irq_ack); end
        cyc(); cyc();
    endtask

    task automatic test_level();
        logic seen;
        irq_req[1] = 1'b1;
        cyc();
        cyc();
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0011) begin n_fail++; $display("FAIL level_trap: irq=%b cause=%h want 1/80000011", irq, irq_cause); end
        cyc();
        irq_req[1] = 1'b0;
        cyc();
        irq_req[1] = 1'b1;
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        n_checks++; if (irq_ret !== 1'b1 || irq_ack !== 16'h0002) begin n_fail++; $display("FAIL level_ret: ret=%b ack=%h want 1/0002", irq_ret, irq_ack); end
        cyc();
        n_checks++; if (dut.pending_q[1] !== 1'b1) begin n_fail++; $display("FAIL level_rearm_pending: got %b want 1", dut.pending_q[1]); end
        cyc();
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0011) begin n_fail++; $display("FAIL level_retrap: irq=%b cause=%h want 1/80000011", irq, irq_cause); end
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (irq !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL level_single_trap: irq seen=%b want 0", seen); end
        n_checks++; if (dut.pending_q !== 16'h0) begin n_fail++; $display("FAIL level_pending_clr: got %h want 0000", dut.pending_q); end
        irq_req[1] = 1'b0;
        cyc();
        irq_req[1] = 1'b1;
        cyc();
        cyc();
        irq_req[1] = 1'b0;
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL level_fresh_trap: irq got %b want 1", irq); end
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        irq_req[1] = 1'b1;
        n_checks++; if (irq_ret !== 1'b1) begin n_fail++; $display("FAIL level_ret2: ret got %b want 1", irq_ret); end
        cyc();
        n_checks++; if (dut.pending_q[1] !== 1'b1) begin n_fail++; $display("FAIL level_return_rise: pending[1] got %b want 1", dut.pending_q[1]); end
        cyc();
        irq_req[1] = 1'b0;
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0011) begin n_fail++; $display("FAIL level_return_retrap: irq=%b cause=%h want 1/80000011", irq, irq_cause); end
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        cyc();
        n_checks++; if (dut.pending_q !== 16'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL level_final_idle: pending=%h irq=%b want 0000/0", dut.pending_q, irq); end
        cyc();
    endtask

    task automatic test_async_reset();
        mie = 32'hFFFF;
        irq_req[0] = 1'b1;
        cyc();
        cyc();
        cyc();
        n_checks++; if (irq !== 1'b0 || irq_cause !== 32'h8000_0010) begin n_fail++; $display("FAIL areset_service: irq=%b cause=%h want 0/80000010", irq, irq_cause); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (irq !== 1'b0 || irq_cause !== 32'h0 || irq_ret !== 1'b0 || irq_ack !== 16'h0) begin
            n_fail++; $display("FAIL areset_outputs: irq=%b cause=%h ret=%b ack=%h want all 0", irq, irq_cause, irq_ret, irq_ack);
        end
        n_checks++; if (dut.pending_q !== 16'h0) begin n_fail++; $display("FAIL areset_pending: got %h want 0000", dut.pending_q); end
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL areset_first: irq got %b want 0", irq); end
        cyc();
        n_checks++; if (irq !== 1'b1 || irq_cause !== 32'h8000_0010) begin n_fail++; $display("FAIL areset_trap: irq=%b cause=%h want 1/80000010", irq, irq_cause); end
        cyc();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        irq_req[0] = 1'b0;
        n_checks++; if (irq_ack !== 16'h0001) begin n_fail++; $display("FAIL areset_ack: got %h want 0001", irq_ack); end
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_stall();
        test_level();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
